// File: rtl/score_display_driver.sv
// score_display_driver: frame-synchronous two-digit score readout on a 4-digit multiplexed 7-segment display with win blink
module score_display_driver #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 25,
    parameter int MAX_SCORE   = 10
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] CURRENT_SCORE,
    output logic [1:0] STROBE_COUNTER,
    output logic [3:0] SEG_SELECT,
    output logic [7:0] HEX_OUT
);
    localparam int TW = $clog2(REFRESH_DIV);
    localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [3:0]    MAX_S      = 4'(MAX_SCORE);

    logic [TW-1:0] tick_cnt;
    logic [BW-1:0] blink_cnt;
    logic [3:0]    score_q;
    logic          phase_on;
    logic          tick;
    logic          frame_end;
    logic          win;
    logic          blank;
    logic [7:0]    d0;
    logic [7:0]    d1;
    logic [7:0]    hex_d;
    logic [3:0]    sel_d;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Digit decode and next output value; the strobe-change cycle and blink-off phase are dark
    always_comb begin
        tick      = tick_cnt == TICK_LAST;
        frame_end = tick && STROBE_COUNTER == 2'd3;
        win       = score_q == MAX_S;
        blank     = tick || (win && !phase_on);
        d0        = score_q > MAX_S ? 8'hBF : seg7(score_q >= 4'd10 ? score_q - 4'd10 : score_q);
        d1        = score_q > MAX_S ? 8'hBF : score_q >= 4'd10 ? 8'hF9 : 8'hFF;
        sel_d     = blank ? 4'hF : ~(4'b0001 << STROBE_COUNTER);
        hex_d     = blank ? 8'hFF : STROBE_COUNTER == 2'd0 ? d0 : STROBE_COUNTER == 2'd1 ? d1 : 8'hFF;
    end

    // Refresh tick divider and digit scan index
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            tick_cnt       <= '0;
            STROBE_COUNTER <= 2'd0;
        end else begin
            tick_cnt       <= tick ? '0 : tick_cnt + TW'(1);
            STROBE_COUNTER <= tick ? STROBE_COUNTER + 2'd1 : STROBE_COUNTER;
        end
    end

    // Score capture and blink phase advance, both only at frame end
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            score_q   <= 4'd0;
            blink_cnt <= '0;
            phase_on  <= 1'b1;
        end else if (frame_end) begin
            score_q   <= CURRENT_SCORE;
            blink_cnt <= (win && blink_cnt != BLINK_LAST) ? blink_cnt + BW'(1) : '0;
            phase_on  <= win ? (blink_cnt == BLINK_LAST ? !phase_on : phase_on) : 1'b1;
        end
    end

    // Registered anode and segment drive
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            SEG_SELECT <= 4'hF;
            HEX_OUT    <= 8'hFF;
        end else begin
            SEG_SELECT <= sel_d;
            HEX_OUT    <= hex_d;
        end
    end
endmodule

// File: tb/tb_score_display_driver.sv
// tb_score_display_driver: directed scoreboard bench for score_display_driver with REFRESH_DIV=4, BLINK_DIV=2
module tb_score_display_driver;
    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [3:0] CURRENT_SCORE = 4'd0;
    logic [1:0] STROBE_COUNTER;
    logic [3:0] SEG_SELECT;
    logic [7:0] HEX_OUT;

    int tests = 0;
    int fails = 0;
    int fidx = 0;
    logic [1:0] ps = 2'd0;

    typedef struct {
        logic       on;
        logic [7:0] d0;
        logic [7:0] d1;
    } frame_t;
    frame_t exp_q[$];

    score_display_driver #(.REFRESH_DIV(4), .BLINK_DIV(2), .MAX_SCORE(10)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .CURRENT_SCORE(CURRENT_SCORE),
        .STROBE_COUNTER(STROBE_COUNTER),
        .SEG_SELECT(SEG_SELECT),
        .HEX_OUT(HEX_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Every scan index change must land on a dark output cycle
    always @(negedge CLK) begin
        if (STROBE_COUNTER != ps)
            check("ghost_guard", {10'd0, SEG_SELECT}, 14'h000F);
        ps = STROBE_COUNTER;
    end

    task automatic push(input logic on, input logic [7:0] d0, input logic [7:0] d1);
        frame_t f;
        f.on = on;
        f.d0 = d0;
        f.d1 = d1;
        exp_q.push_back(f);
    endtask

    task automatic check_frames(input int n, input int chg);
        logic [1:0] p;
        logic       ok;
        int         w;
        frame_t     f;
        logic [3:0] sel;
        logic [7:0] hex;
        for (int i = 0; i < n; i++) begin
            p = STROBE_COUNTER;
            w = 0;
            do begin
                @(negedge CLK);
                w++;
                ok = STROBE_COUNTER == 2'd0 && p == 2'd3;
                p = STROBE_COUNTER;
            end while (!ok && w < 40);
            check("frame_sync", {13'd0, ok}, 14'd1);
            f = exp_q.pop_front();
            for (int c = 0; c < 16; c++) begin
                if (c > 0) @(negedge CLK);
                if (i == 0 && chg >= 0 && c == 5) CURRENT_SCORE = 4'(chg);
                if (c % 4 == 0 || !f.on) begin
                    sel = 4'hF;
                    hex = 8'hFF;
                end else begin
                    sel = ~(4'b0001 << (c / 4));
                    hex = c / 4 == 0 ? f.d0 : c / 4 == 1 ? f.d1 : 8'hFF;
                end
                check($sformatf("frame%0d_c%0d", fidx, c), {STROBE_COUNTER, SEG_SELECT, HEX_OUT}, {2'(c / 4), sel, hex});
            end
            fidx++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        RESET = 1'b0;
        CURRENT_SCORE = 4'd0;
        repeat (3) @(negedge CLK);
        check("reset_state", {STROBE_COUNTER, SEG_SELECT, HEX_OUT}, {2'd0, 4'hF, 8'hFF});
        RESET = 1'b1;
        push(1'b1, 8'hC0, 8'hFF);
        push(1'b1, 8'hC0, 8'hFF);
        check_frames(2, -1);
        CURRENT_SCORE = 4'd3;
        push(1'b1, 8'hB0, 8'hFF);
        check_frames(1, -1);
        push(1'b1, 8'hB0, 8'hFF);
        push(1'b1, 8'hF8, 8'hFF);
        check_frames(2, 7);
        CURRENT_SCORE = 4'd10;
        push(1'b1, 8'hC0, 8'hF9);
        push(1'b1, 8'hC0, 8'hF9);
        push(1'b0, 8'hC0, 8'hF9);
        push(1'b0, 8'hC0, 8'hF9);
        push(1'b1, 8'hC0, 8'hF9);
        push(1'b1, 8'hC0, 8'hF9);
        push(1'b0, 8'hC0, 8'hF9);
        check_frames(7, -1);
        CURRENT_SCORE = 4'd9;
        push(1'b1, 8'h90, 8'hFF);
        push(1'b1, 8'h90, 8'hFF);
        check_frames(2, -1);
        CURRENT_SCORE = 4'd12;
        push(1'b1, 8'hBF, 8'hBF);
        push(1'b1, 8'hBF, 8'hBF);
        check_frames(2, -1);
        CURRENT_SCORE = 4'd15;
        push(1'b1, 8'hBF, 8'hBF);
        check_frames(1, -1);
        CURRENT_SCORE = 4'd10;
        push(1'b1, 8'hC0, 8'hF9);
        push(1'b1, 8'hC0, 8'hF9);
        check_frames(2, -1);
        found = 1'b0;
        for (int t = 0; t < 40 && !found; t++) begin
            @(negedge CLK);
            found = STROBE_COUNTER == 2'd2;
        end
        check("reach_strobe2", {13'd0, found}, 14'd1);
        check("blink_off_s2", {STROBE_COUNTER, SEG_SELECT, HEX_OUT}, {2'd2, 4'hF, 8'hFF});
        RESET = 1'b0;
        @(negedge CLK);
        check("mid_reset", {STROBE_COUNTER, SEG_SELECT, HEX_OUT}, {2'd0, 4'hF, 8'hFF});
        RESET = 1'b1;
        @(negedge CLK);
        check("post_reset_d0", {STROBE_COUNTER, SEG_SELECT, HEX_OUT}, {2'd0, 4'hE, 8'hC0});
        CURRENT_SCORE = 4'd5;
        push(1'b1, 8'h92, 8'hFF);
        check_frames(1, -1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/score_display_driver.md
Name: score_display_driver

Overview:
- Downstream consumer of the 4-bit score counter output (CURRENT_SCORE, range 0..10).
- Converts the score to two decimal digits and drives a 4-digit multiplexed common-anode 7-segment display.
- Samples the score once per full scan frame, so digits never tear mid-frame.
- Blinks the display when the winning score is reached.

Parameters:
- REFRESH_DIV, 50000, CLK cycles each digit stays lit (must be >= 2).
- BLINK_DIV, 25, scan frames per blink half-period (must be >= 1).
- MAX_SCORE, 10, score value that triggers win blink.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- RESET  input  1  synchronous, active-low (0 = reset).
- CURRENT_SCORE  input  4  score from the score counter; may change on any cycle.
- STROBE_COUNTER  output  2  index of the digit currently being scanned (0 = rightmost).
- SEG_SELECT  output  4  digit anodes, active-low, one-hot-low when lit.
- HEX_OUT  output  8  segments, active-low; [7]=DP, [6:0]=g..a.

Behaviour:
- Reset (RESET=0 at posedge), applied on that edge:
  - tick counter=0, STROBE_COUNTER=0, captured score=0.
  - blink frame counter=0, blink phase=ON.
  - SEG_SELECT=4'b1111, HEX_OUT=8'hFF.
  - Reset mid-scan aborts the frame immediately; no partial-digit carry-over.
- Tick counter counts 0..REFRESH_DIV-1 and wraps. tick=1 for exactly one cycle at the terminal count.
- On tick, STROBE_COUNTER increments mod 4 (3 -> 0 wrap = frame end).
- Frame end is tick with STROBE_COUNTER==3. On that edge:
  - captured score <= CURRENT_SCORE.
  - blink frame counter advances.
- CURRENT_SCORE changes at any other time are ignored until the next frame end. Worst-case display latency is 4*REFRESH_DIV cycles.
- Digit contents, computed from captured score S:
  - S 0..9: digit0 = S; digit1, digit2, digit3 = blank.
  - S 10..15: digit1 = 1; digit0 = S-10.
  - S > MAX_SCORE: digit0 = dash (8'hBF); digit1 = dash. Out-of-range indicator; never expected.
  - Digits 2 and 3 are always blank. Their anodes are still strobed, so brightness duty stays 1/4.
- Segment codes (active-low, DP off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - blank=FF, dash=BF.
- Output register:
  - SEG_SELECT and HEX_OUT are registered.
  - They reflect the STROBE_COUNTER value of the previous cycle, i.e. 1-cycle latency.
  - SEG_SELECT = ~(1 << STROBE_COUNTER_prev).
- Ghosting guard: on the cycle STROBE_COUNTER changes, SEG_SELECT is forced to 4'b1111 for exactly that output cycle, then the new digit is lit.
- Win blink:
  - win = (captured score == MAX_SCORE).
  - While win: blink frame counter counts frames 0..BLINK_DIV-1; phase toggles at terminal count.
  - Phase OFF: SEG_SELECT=4'b1111 and HEX_OUT=8'hFF; scanning continues.
  - When win is 0: blink frame counter is held at 0 and phase is forced ON at the next frame end.
- Simultaneous events:
  - Frame-end capture and blink advance occur on the same edge.
  - Blink decision uses the newly captured score from the following cycle onward.
- No overflow is possible: all counters wrap explicitly. Tick counter width is ceil(log2(REFRESH_DIV)).

Test Plan (REFRESH_DIV=4, BLINK_DIV=2):
- Reset, then RESET=1, CURRENT_SCORE=0 -> after first frame end:
  - digit0 slot: SEG_SELECT=1110, HEX_OUT=C0.
  - digit1..3 slots: SEG_SELECT one-hot-low, HEX_OUT=FF.
  - STROBE_COUNTER cycles 0,1,2,3 every 4 clocks.
- CURRENT_SCORE 3 -> 7 toggled mid-frame (STROBE_COUNTER=1) -> display holds 3 (B0) until frame end, then shows 7 (F8). No frame shows a mix.
- CURRENT_SCORE=10 -> after frame end:
  - digit0=C0, digit1=F9 for 2 frames.
  - then all SEG_SELECT=1111, HEX_OUT=FF for 2 frames; repeats.
  - Score back to 9: next frame shows 90 steady, phase ON.
- CURRENT_SCORE=12 -> digit0 and digit1 both BF; no blink.
- RESET=0 asserted while STROBE_COUNTER=2 and blink phase OFF -> next edge: all outputs and counters at reset values. First post-reset frame shows score 0.
- Every STROBE_COUNTER transition -> exactly one output cycle with SEG_SELECT=1111 (ghosting guard checked by assertion throughout).
